turn_signal_sequencer: RTL and testbench
========================================

# turn_signal_sequencer

Sequencer that turns the driver's raw stalk and hazard switches into the `turn_left` / `turn_right` lamp drives consumed by the lighting block. It synchronises and debounces the switches, then arbitrates between hazard, left and right requests. It generates a phase-aligned blink, implements the three-flash lane-change comfort blink, and emits a one-cycle click pulse for the buzzer. It sits between the switch inputs and the lighting block's turn inputs.

## Interface
- `HALF_CYC`, 500000: clock cycles per blink half-period (lamp ON time = OFF time).
- `DEBOUNCE_CYC`, 10000: consecutive stable cycles required before a switch change is accepted.
- `SHORT_CYC`, 400000: a left/right activation shorter than this is a short press and triggers the comfort blink.
- `COMFORT_BLINKS`, 3: number of ON flashes in a comfort blink.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low: `rst`=0 resets all state immediately.
- `sw_left`  in  1  raw left stalk, async to clk.
- `sw_right`  in  1  raw right stalk, async to clk.
- `sw_hazard`  in  1  raw hazard switch, async to clk.
- `turn_left`  out  1  left lamp drive, registered.
- `turn_right`  out  1  right lamp drive, registered.
- `click`  out  1  one-cycle pulse on every lamp transition.
- `blink_cnt`  out  4  ON phases started in the current activation, saturating at 15.
- `hazard_active`  out  1  high while in the HAZARD state.

## Operation
- **Input conditioning (per switch):**
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced value; it clears when they are equal.
  - When the count reaches `DEBOUNCE_CYC`-1 and the values still differ, the debounced value is updated.
- **Request decode:**
  - `req_h` is the debounced hazard.
  - `req_l` = left and not right; `req_r` = right and not left.
  - Left and right both high is illegal and treated as no direction request.
- **FSM states:** IDLE, LEFT, RIGHT, HAZARD, COMFORT_L, COMFORT_R.
- **Transitions** (priority is HAZARD > direction > hold):
  - any state with `req_h` -> HAZARD.
  - IDLE: `req_l` -> LEFT; `req_r` -> RIGHT.
  - LEFT / RIGHT: opposite request -> that direction; request dropped with `active_cnt` < `SHORT_CYC` -> COMFORT_L / COMFORT_R; request dropped otherwise -> IDLE.
  - COMFORT_x: opposite request -> that direction; same-side request re-asserted -> back to LEFT / RIGHT without restarting the phase; `blink_cnt` >= `COMFORT_BLINKS` at the end of an ON phase, or while in an OFF phase -> IDLE.
  - HAZARD, on `req_h` drop: `req_l` -> LEFT, `req_r` -> RIGHT, else IDLE.
- **Phase generator:**
  - On entry to LEFT, RIGHT or HAZARD from any other state, `phase_cnt` clears to 0, the phase is ON, and `blink_cnt` is set to 1.
  - `phase_cnt` counts 0..`HALF_CYC`-1 and wraps, toggling the phase on each wrap.
  - Each OFF->ON toggle increments `blink_cnt`, saturating at 15.
  - LEFT <-> COMFORT_L (and the right-side pair) keep the phase running.
- **Lamps:**
  - `turn_left` = phase ON and state is LEFT, COMFORT_L or HAZARD.
  - `turn_right` = phase ON and state is RIGHT, COMFORT_R or HAZARD.
  - In HAZARD both lamps are always in phase.
- **`active_cnt`:** counts cycles since entry into LEFT/RIGHT and saturates at `SHORT_CYC`.
- **`click`:** high for one cycle whenever `turn_left` or `turn_right` changes value.
- **Entering IDLE:** lamps go low, `blink_cnt` goes to 0, `active_cnt` goes to 0.

## Timing
- Reset values: `turn_left`=0, `turn_right`=0, `click`=0, `blink_cnt`=0, `hazard_active`=0; state IDLE; all counters and debounced values 0.
- Raw switch edge to lamp change: `DEBOUNCE_CYC`+3 rising edges (2 sync, `DEBOUNCE_CYC` debounce, 1 FSM/lamp register).
- Lamps and state are registered on the same edge. `click` is registered one edge after the lamp change.
- Glitches shorter than `DEBOUNCE_CYC` cycles have no effect.
- Reset asserted mid-blink: outputs go to their reset values immediately, without waiting for a clock edge. After release, held switches are re-accepted only after a full debounce.
- Source change (e.g. LEFT -> RIGHT, or HAZARD entry): the new lamp turns ON in the same cycle the old lamp goes off. `click` pulses once.

## Test plan
Bench parameters: `HALF_CYC`=8, `DEBOUNCE_CYC`=4, `SHORT_CYC`=20, `COMFORT_BLINKS`=3.

1. **Long left hold:** `sw_left` high at edge 0, held 60 cycles -> `turn_left` rises at edge 7 and toggles every 8 cycles. `turn_left` falls 7 edges after release; `blink_cnt` reaches 4 or 5, then returns to 0.
2. **Comfort blink:** `sw_left` high for 10 cycles -> exactly 3 `turn_left` pulses of 8 cycles, separated by 8-cycle gaps. Then IDLE with `blink_cnt`=0 and 6 `click` pulses in total.
3. **Hazard override:** left blinking, then `sw_hazard` asserted -> both lamps ON together at `DEBOUNCE_CYC`+3 and `hazard_active`=1. Release hazard with left held -> LEFT, with the phase restarted ON.
4. **Illegal and glitch inputs:** left and right both high -> no lamp activity. A 3-cycle pulse on `sw_right` -> no lamp activity.
5. **Direction switch during comfort:** in COMFORT_L, assert `sw_right` -> `turn_left` goes 0 and `turn_right` goes 1 on the same edge, with `blink_cnt`=1.
6. **Async reset mid-hazard:** drive `rst`=0 between clock edges -> all outputs 0 before the next edge. Release with hazard held -> lamps back on after 7 edges.

Source files
------------

// File: rtl/turn_signal_sequencer.sv
`default_nettype none
// turn_signal_sequencer - stalk/hazard conditioning, lamp arbitration, blink and comfort-blink generation
// Rev 1.0
module turn_signal_sequencer #(
  parameter int HALF_CYC       = 500000,
  parameter int DEBOUNCE_CYC   = 10000,
  parameter int SHORT_CYC      = 400000,
  parameter int COMFORT_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  output logic       turn_left,
  output logic       turn_right,
  output logic       click,
  output logic [3:0] blink_cnt,
  output logic       hazard_active
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PH_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int AC_W = $clog2(SHORT_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF_CYC - 1);
  localparam logic [AC_W-1:0] SHORT_AC = AC_W'(SHORT_CYC);
  localparam logic [3:0]      CB_MAX   = 4'((COMFORT_BLINKS > 15) ? 15 : COMFORT_BLINKS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    HAZARD    = 3'd3,
    COMFORT_L = 3'd4,
    COMFORT_R = 3'd5
  } state_t;

  // bit 0 = left, bit 1 = right, bit 2 = hazard
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      deb;
  logic [DB_W-1:0] db_cnt [3];

  assign raw = {sw_hazard, sw_right, sw_left};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic req_h, req_l, req_r;
  assign req_h = deb[2];
  assign req_l = deb[0] & ~deb[1];
  assign req_r = deb[1] & ~deb[0];

  state_t          state, state_nxt;
  logic [PH_W-1:0] phase_cnt, phase_cnt_nxt;
  logic            phase_on, phase_on_nxt;
  logic [3:0]      blink_nxt;
  logic [AC_W-1:0] active_cnt, active_nxt;
  logic            left_nxt, right_nxt;
  logic            wrap, comfort_done, keep, restart;
  logic            prev_left, prev_right;

  assign wrap         = (phase_cnt == PH_LAST);
  assign comfort_done = (blink_cnt >= CB_MAX) && (!phase_on || wrap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_h)      state_nxt = HAZARD;
        else if (req_l) state_nxt = LEFT;
        else if (req_r) state_nxt = RIGHT;
      end
      LEFT: begin
        if (req_h)       state_nxt = HAZARD;
        else if (req_r)  state_nxt = RIGHT;
        else if (!req_l) state_nxt = (active_cnt < SHORT_AC) ? COMFORT_L : IDLE;
      end
      RIGHT: begin
        if (req_h)       state_nxt = HAZARD;
        else if (req_l)  state_nxt = LEFT;
        else if (!req_r) state_nxt = (active_cnt < SHORT_AC) ? COMFORT_R : IDLE;
      end
      COMFORT_L: begin
        if (req_h)             state_nxt = HAZARD;
        else if (req_r)        state_nxt = RIGHT;
        else if (req_l)        state_nxt = LEFT;
        else if (comfort_done) state_nxt = IDLE;
      end
      COMFORT_R: begin
        if (req_h)             state_nxt = HAZARD;
        else if (req_l)        state_nxt = LEFT;
        else if (req_r)        state_nxt = RIGHT;
        else if (comfort_done) state_nxt = IDLE;
      end
      HAZARD: begin
        if (!req_h) begin
          if (req_l)      state_nxt = LEFT;
          else if (req_r) state_nxt = RIGHT;
          else            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Moving between a direction and its comfort state keeps the blink running
    keep = (state == state_nxt)
        || (state == LEFT      && state_nxt == COMFORT_L)
        || (state == COMFORT_L && state_nxt == LEFT)
        || (state == RIGHT     && state_nxt == COMFORT_R)
        || (state == COMFORT_R && state_nxt == RIGHT);
    restart = !keep && (state_nxt inside {LEFT, RIGHT, HAZARD});

    phase_cnt_nxt = wrap ? '0 : phase_cnt + 1'b1;
    phase_on_nxt  = phase_on ^ wrap;
    blink_nxt     = (wrap && !phase_on && blink_cnt != 4'd15) ? blink_cnt + 4'd1 : blink_cnt;
    active_nxt    = active_cnt;

    if (state_nxt == IDLE) begin
      phase_cnt_nxt = '0;
      phase_on_nxt  = 1'b0;
      blink_nxt     = 4'd0;
      active_nxt    = '0;
    end else if (restart) begin
      phase_cnt_nxt = '0;
      phase_on_nxt  = 1'b1;
      blink_nxt     = 4'd1;
      active_nxt    = '0;
    end else if ((state_nxt inside {LEFT, RIGHT}) && active_cnt != SHORT_AC) begin
      active_nxt = active_cnt + 1'b1;
    end

    left_nxt  = phase_on_nxt && (state_nxt inside {LEFT, COMFORT_L, HAZARD});
    right_nxt = phase_on_nxt && (state_nxt inside {RIGHT, COMFORT_R, HAZARD});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_cnt  <= '0;
      phase_on   <= 1'b0;
      blink_cnt  <= 4'd0;
      active_cnt <= '0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      click      <= 1'b0;
    end else begin
      phase_cnt  <= phase_cnt_nxt;
      phase_on   <= phase_on_nxt;
      blink_cnt  <= blink_nxt;
      active_cnt <= active_nxt;
      turn_left  <= left_nxt;
      turn_right <= right_nxt;
      prev_left  <= turn_left;
      prev_right <= turn_right;
      click      <= (turn_left != prev_left) || (turn_right != prev_right);
    end
  end

  assign hazard_active = (state == HAZARD);

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_sequencer.sv
`default_nettype none
// tb_turn_signal_sequencer - directed checks of lamp timing, comfort blink, hazard and reset behaviour
// Rev 1.0
module tb_turn_signal_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_left = 1'b0;
  logic       sw_right = 1'b0;
  logic       sw_hazard = 1'b0;
  logic       turn_left, turn_right, click, hazard_active;
  logic [3:0] blink_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int edge_no = 0;
  int click_total = 0;
  int click_base = 0;

  turn_signal_sequencer #(
    .HALF_CYC(8), .DEBOUNCE_CYC(4), .SHORT_CYC(20), .COMFORT_BLINKS(3)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_left(sw_left), .sw_right(sw_right), .sw_hazard(sw_hazard),
    .turn_left(turn_left), .turn_right(turn_right), .click(click),
    .blink_cnt(blink_cnt), .hazard_active(hazard_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (click === 1'b1) click_total++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  // Edge numbers are relative to the start of each test; sampling is 1ns after the edge
  task automatic goto(input int k);
    repeat (k - edge_no) @(posedge clk);
    #1;
    edge_no = k;
  endtask

  task automatic new_test();
    @(posedge clk);
    #1;
    edge_no = 0;
  endtask

  task automatic lamps(input string tag, input logic l, input logic r);
    check_eq({tag, "_left"}, 32'(turn_left), 32'(l));
    check_eq({tag, "_right"}, 32'(turn_right), 32'(r));
  endtask

  initial begin
    #1 rst = 1'b0;
    #11;
    lamps("reset", 1'b0, 1'b0);
    check_eq("reset_click", 32'(click), 0);
    check_eq("reset_blink", 32'(blink_cnt), 0);
    check_eq("reset_hazard", 32'(hazard_active), 0);
    #11 rst = 1'b1;

    // Long left hold
    new_test();
    sw_left = 1'b1;
    goto(6);  lamps("t1_e6", 1'b0, 1'b0);
    goto(7);  lamps("t1_e7", 1'b1, 1'b0);
    check_eq("t1_e7_blink", 32'(blink_cnt), 1);
    check_eq("t1_e7_click", 32'(click), 0);
    goto(8);  check_eq("t1_e8_click", 32'(click), 1);
    goto(9);  check_eq("t1_e9_click", 32'(click), 0);
    goto(14); lamps("t1_e14", 1'b1, 1'b0);
    goto(15); lamps("t1_e15", 1'b0, 1'b0);
    goto(23); lamps("t1_e23", 1'b1, 1'b0);
    check_eq("t1_e23_blink", 32'(blink_cnt), 2);
    goto(55); check_eq("t1_e55_blink", 32'(blink_cnt), 4);
    goto(60); sw_left = 1'b0;
    goto(63); lamps("t1_e63", 1'b0, 1'b0);
    goto(66); check_eq("t1_e66_blink", 32'(blink_cnt), 4);
    goto(67); check_eq("t1_e67_blink", 32'(blink_cnt), 0);
    goto(72); lamps("t1_e72", 1'b0, 1'b0);

    // Comfort blink from a 10-cycle tap
    new_test();
    click_base = click_total;
    sw_left = 1'b1;
    goto(7);  lamps("t2_e7", 1'b1, 1'b0);
    goto(10); sw_left = 1'b0;
    goto(15); lamps("t2_e15", 1'b0, 1'b0);
    goto(22); lamps("t2_e22", 1'b0, 1'b0);
    goto(23); lamps("t2_e23", 1'b1, 1'b0);
    check_eq("t2_e23_blink", 32'(blink_cnt), 2);
    goto(39); lamps("t2_e39", 1'b1, 1'b0);
    check_eq("t2_e39_blink", 32'(blink_cnt), 3);
    goto(46); lamps("t2_e46", 1'b1, 1'b0);
    goto(47); lamps("t2_e47", 1'b0, 1'b0);
    check_eq("t2_e47_blink", 32'(blink_cnt), 0);
    goto(56); lamps("t2_e56", 1'b0, 1'b0);
    check_eq("t2_e56_hazard", 32'(hazard_active), 0);
    goto(60); check_eq("t2_clicks", 32'(click_total - click_base), 6);

    // Hazard override, return to left, then right during comfort
    new_test();
    sw_left = 1'b1;
    goto(7);  lamps("t3_e7", 1'b1, 1'b0);
    goto(12); sw_hazard = 1'b1;
    goto(18); lamps("t3_e18", 1'b0, 1'b0);
    check_eq("t3_e18_hazard", 32'(hazard_active), 0);
    goto(19); lamps("t3_e19", 1'b1, 1'b1);
    check_eq("t3_e19_hazard", 32'(hazard_active), 1);
    check_eq("t3_e19_blink", 32'(blink_cnt), 1);
    goto(27); lamps("t3_e27", 1'b0, 1'b0);
    goto(35); lamps("t3_e35", 1'b1, 1'b1);
    check_eq("t3_e35_blink", 32'(blink_cnt), 2);
    goto(36); sw_hazard = 1'b0;
    goto(42); lamps("t3_e42", 1'b1, 1'b1);
    goto(43); lamps("t3_e43", 1'b1, 1'b0);
    check_eq("t3_e43_blink", 32'(blink_cnt), 1);
    check_eq("t3_e43_hazard", 32'(hazard_active), 0);
    goto(50); lamps("t3_e50", 1'b1, 1'b0);
    goto(51); lamps("t3_e51", 1'b0, 1'b0);
    goto(52); sw_left = 1'b0;
    goto(55); sw_right = 1'b1;
    goto(59); lamps("t5_e59", 1'b1, 1'b0);
    check_eq("t5_e59_blink", 32'(blink_cnt), 2);
    goto(61); lamps("t5_e61", 1'b1, 1'b0);
    goto(62); lamps("t5_e62", 1'b0, 1'b1);
    check_eq("t5_e62_blink", 32'(blink_cnt), 1);
    goto(63); check_eq("t5_e63_click", 32'(click), 1);
    goto(64); check_eq("t5_e64_click", 32'(click), 0);
    sw_right = 1'b0;
    goto(94); lamps("t5_e94", 1'b0, 1'b1);
    check_eq("t5_e94_blink", 32'(blink_cnt), 3);
    goto(102); lamps("t5_e102", 1'b0, 1'b0);
    check_eq("t5_e102_blink", 32'(blink_cnt), 0);

    // Illegal both-directions request and short glitch
    new_test();
    sw_left = 1'b1;
    sw_right = 1'b1;
    goto(7);  lamps("t4_e7", 1'b0, 1'b0);
    goto(15); lamps("t4_e15", 1'b0, 1'b0);
    check_eq("t4_e15_blink", 32'(blink_cnt), 0);
    goto(20); sw_left = 1'b0; sw_right = 1'b0;
    goto(30); sw_right = 1'b1;
    goto(33); sw_right = 1'b0;
    goto(38); lamps("t4_e38", 1'b0, 1'b0);
    goto(41); lamps("t4_e41", 1'b0, 1'b0);

    // Asynchronous reset during hazard
    new_test();
    sw_hazard = 1'b1;
    goto(7);  lamps("t6_e7", 1'b1, 1'b1);
    check_eq("t6_e7_hazard", 32'(hazard_active), 1);
    goto(10); lamps("t6_e10", 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    lamps("t6_async", 1'b0, 1'b0);
    check_eq("t6_async_click", 32'(click), 0);
    check_eq("t6_async_blink", 32'(blink_cnt), 0);
    check_eq("t6_async_hazard", 32'(hazard_active), 0);
    goto(12); lamps("t6_e12", 1'b0, 1'b0);
    #2 rst = 1'b1;
    goto(18); lamps("t6_e18", 1'b0, 1'b0);
    goto(19); lamps("t6_e19", 1'b1, 1'b1);
    check_eq("t6_e19_hazard", 32'(hazard_active), 1);
    check_eq("t6_e19_blink", 32'(blink_cnt), 1);
    sw_hazard = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
